// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core front end: branch directions, PHT counter type and
// the gshare predictor state encoding, plus the 2-bit counter training rule.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_outcome;

  typedef logic [1:0] pht_cnt_t;
  localparam pht_cnt_t PHT_WEAK_NT = 2'b01;

  typedef enum logic {
    GP_INIT,
    GP_READY
  } gp_state_e;

  // Saturating 2-bit counter step: taken climbs toward 11, not-taken falls toward 00.
  function automatic pht_cnt_t pht_train(input pht_cnt_t cnt, input logic taken);
    pht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// Pattern-history table: one combinational read port and one write port that either
// stores the weakly-not-taken init value or trains the addressed counter in place.
module gshare_predictor_pht
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output pht_cnt_t              rd_cnt,
  input  logic                  wr_en,
  input  logic                  wr_init,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int DEPTH = 1 << INDEX_BITS;

  pht_cnt_t cnt_q [DEPTH];
  pht_cnt_t wr_cnt;

  // Read-before-write: a same-cycle write lands on the edge, after this read is used.
  assign rd_cnt = cnt_q[rd_idx];

  always_comb begin
    wr_cnt = wr_init ? PHT_WEAK_NT : pht_train(cnt_q[wr_idx], wr_taken);
  end

  // NOTE: the table has no reset; the INIT sweep defines every entry before it is
  // ever read, so resetting 2^INDEX_BITS flops would only cost area and fanout.
  always_ff @(posedge clk) begin
    if (wr_en) cnt_q[wr_idx] <= wr_cnt;
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare conditional-branch direction predictor: PHT init sweep, hashed lookup and
// training, speculative global history with misprediction repair, perf counters.
module gshare_predictor
  import mips_core_pkg::*;
#(
  parameter int PHT_INDEX_BITS = 10,
  parameter int GHR_BITS       = 10,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_accept,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_prediction,
  output logic [GHR_BITS-1:0]   o_req_ghr_snap,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [GHR_BITS-1:0]   i_fb_ghr_snap,
  input  logic                  i_fb_prediction,
  input  logic                  i_fb_outcome,
  output logic                  o_ready,
  output logic [CNT_WIDTH-1:0]  o_lookups,
  output logic [CNT_WIDTH-1:0]  o_mispredicts
);

  if (GHR_BITS > PHT_INDEX_BITS || GHR_BITS < 2) begin : g_bad_cfg
    $error("gshare_predictor: GHR_BITS must be in 2..PHT_INDEX_BITS");
  end

  localparam logic [PHT_INDEX_BITS-1:0] LAST_IDX = '1;

  gp_state_e                 state_q, state_d;
  logic [PHT_INDEX_BITS-1:0] init_idx_q, init_idx_d;
  logic [GHR_BITS-1:0]       spec_ghr_q, spec_ghr_d;

  logic [PHT_INDEX_BITS-1:0] req_ghr_ext, fb_ghr_ext;
  logic [PHT_INDEX_BITS-1:0] req_idx, fb_idx;
  logic [PHT_INDEX_BITS-1:0] pht_wr_idx;
  logic                      pht_wr_en, pht_wr_init;
  pht_cnt_t                  pht_rd_cnt;
  branch_outcome             req_dir;
  logic                      accept, mispredict, in_init;

  // Only the word-aligned index bits of each PC feed the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:PHT_INDEX_BITS+2], i_req_pc[1:0],
                            i_fb_pc[ADDR_WIDTH-1:PHT_INDEX_BITS+2], i_fb_pc[1:0]};

  // ---------------- init sweep FSM ----------------
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      GP_INIT: begin
        init_idx_d = init_idx_q + PHT_INDEX_BITS'(1);
        if (init_idx_q == LAST_IDX) state_d = GP_READY;
      end
      GP_READY: state_d = GP_READY;
      default:  state_d = GP_INIT;
    endcase
  end

  assign in_init = (state_q == GP_INIT);
  assign o_ready = (state_q == GP_READY);

  // ---------------- index hashing ----------------
  // History is zero-extended up to the index width before the XOR.
  always_comb begin
    req_ghr_ext                 = '0;
    req_ghr_ext[GHR_BITS-1:0]   = spec_ghr_q;
    fb_ghr_ext                  = '0;
    fb_ghr_ext[GHR_BITS-1:0]    = i_fb_ghr_snap;
  end

  assign req_idx = i_req_pc[PHT_INDEX_BITS+1:2] ^ req_ghr_ext;
  assign fb_idx  = i_fb_pc[PHT_INDEX_BITS+1:2] ^ fb_ghr_ext;

  // Training is suppressed while the sweep owns the write port.
  assign pht_wr_init = in_init;
  assign pht_wr_en   = in_init | i_fb_valid;
  assign pht_wr_idx  = in_init ? init_idx_q : fb_idx;

  gshare_predictor_pht #(
    .INDEX_BITS (PHT_INDEX_BITS)
  ) u_pht (
    .clk      (clk),
    .rd_idx   (req_idx),
    .rd_cnt   (pht_rd_cnt),
    .wr_en    (pht_wr_en),
    .wr_init  (pht_wr_init),
    .wr_idx   (pht_wr_idx),
    .wr_taken (i_fb_outcome)
  );

  assign req_dir          = (o_ready && pht_rd_cnt[1]) ? TAKEN : NOT_TAKEN;
  assign o_req_prediction = (req_dir == TAKEN);
  assign o_req_ghr_snap   = spec_ghr_q;

  // ---------------- speculative history ----------------
  assign accept     = i_req_valid & i_req_accept;
  assign mispredict = i_fb_valid & (i_fb_prediction != i_fb_outcome);

  // Repair wins over a same-cycle accept: that younger branch is on the wrong path.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (mispredict) begin
      spec_ghr_d = {i_fb_ghr_snap[GHR_BITS-2:0], i_fb_outcome};
    end else if (accept) begin
      spec_ghr_d = {spec_ghr_q[GHR_BITS-2:0], o_req_prediction};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= GP_INIT;
      init_idx_q    <= '0;
      spec_ghr_q    <= '0;
      o_lookups     <= '0;
      o_mispredicts <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      spec_ghr_q <= spec_ghr_d;
      if (accept && (o_lookups != '1)) o_lookups <= o_lookups + CNT_WIDTH'(1);
      if (mispredict && (o_mispredicts != '1)) o_mispredicts <= o_mispredicts + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor against an array-based reference model
// of the predictor's architectural behaviour.
module tb_gshare_predictor;
  import mips_core_pkg::*;

  localparam int ENTRIES = 1024;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_req_valid = 1'b0;
  logic                  i_req_accept = 1'b0;
  logic [ADDR_WIDTH-1:0] i_req_pc = '0;
  logic                  o_req_prediction;
  logic [9:0]            o_req_ghr_snap;
  logic                  i_fb_valid = 1'b0;
  logic [ADDR_WIDTH-1:0] i_fb_pc = '0;
  logic [9:0]            i_fb_ghr_snap = '0;
  logic                  i_fb_prediction = 1'b0;
  logic                  i_fb_outcome = 1'b0;
  logic                  o_ready;
  logic [31:0]           o_lookups;
  logic [31:0]           o_mispredicts;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          pht_m [ENTRIES];
  int          ghr_m;
  logic [31:0] lookups_m;
  logic [31:0] misp_m;
  int          init_cycles_m;
  bit          ready_m;

  always #5 clk = ~clk;

  gshare_predictor #(
    .PHT_INDEX_BITS (10),
    .GHR_BITS       (10),
    .CNT_WIDTH      (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .i_req_accept     (i_req_accept),
    .i_req_pc         (i_req_pc),
    .o_req_prediction (o_req_prediction),
    .o_req_ghr_snap   (o_req_ghr_snap),
    .i_fb_valid       (i_fb_valid),
    .i_fb_pc          (i_fb_pc),
    .i_fb_ghr_snap    (i_fb_ghr_snap),
    .i_fb_prediction  (i_fb_prediction),
    .i_fb_outcome     (i_fb_outcome),
    .o_ready          (o_ready),
    .o_lookups        (o_lookups),
    .o_mispredicts    (o_mispredicts)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int hash_idx(input logic [31:0] pc, input int ghr);
    return int'(((pc >> 2) ^ 32'(ghr)) & 32'(ENTRIES - 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) pht_m[i] = 1;
    ghr_m         = 0;
    lookups_m     = '0;
    misp_m        = '0;
    init_cycles_m = 0;
    ready_m       = 1'b0;
  endtask

  // Drives one cycle (called at a falling edge), samples the combinational outputs,
  // advances the model, and returns at the next falling edge with inputs idle.
  task automatic apply(input bit rv, input bit acc, input logic [31:0] pc,
                       input bit fv, input logic [31:0] fpc, input int fsnap,
                       input bit fpred, input bit fout,
                       output logic pred_obs, output logic [9:0] snap_obs,
                       output bit pred_exp, output int snap_exp);
    int ridx, fidx;
    bit misp;
    i_req_valid     = rv;
    i_req_accept    = acc;
    i_req_pc        = pc;
    i_fb_valid      = fv;
    i_fb_pc         = fpc;
    i_fb_ghr_snap   = 10'(fsnap);
    i_fb_prediction = fpred;
    i_fb_outcome    = fout;
    #1;
    pred_obs = o_req_prediction;
    snap_obs = o_req_ghr_snap;
    ridx     = hash_idx(pc, ghr_m);
    pred_exp = ready_m && (pht_m[ridx] >= 2);
    snap_exp = ghr_m;
    misp     = fv && (fpred != fout);
    if (fv && ready_m) begin
      fidx = hash_idx(fpc, fsnap);
      if (fout) begin
        if (pht_m[fidx] < 3) pht_m[fidx]++;
      end else if (pht_m[fidx] > 0) begin
        pht_m[fidx]--;
      end
    end
    if (misp) ghr_m = ((fsnap << 1) | int'(fout)) & (ENTRIES - 1);
    else if (rv && acc) ghr_m = ((ghr_m << 1) | int'(pred_exp)) & (ENTRIES - 1);
    if (rv && acc && lookups_m != 32'hFFFF_FFFF) lookups_m++;
    if (misp && misp_m != 32'hFFFF_FFFF) misp_m++;
    init_cycles_m++;
    ready_m = (init_cycles_m >= ENTRIES);
    @(posedge clk);
    @(negedge clk);
    i_req_valid  = 1'b0;
    i_req_accept = 1'b0;
    i_fb_valid   = 1'b0;
  endtask

  task automatic test_reset();
    logic po; logic [9:0] so; bit pe; int se;
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", o_ready); end
    checks++;
    if (o_req_ghr_snap !== 10'h000) begin errors++; $display("FAIL reset_ghr: got %0h expected 0", o_req_ghr_snap); end
    checks++;
    if (o_lookups !== 32'd0 || o_mispredicts !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", o_lookups, o_mispredicts);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i == 0) apply(1, 0, 32'h0040_0010, 0, 0, 0, 0, 0, po, so, pe, se);
      else if (i == 5) apply(0, 0, 0, 1, 32'h0040_0010, 0, 1, 1, po, so, pe, se);
      else apply(0, 0, 0, 0, 0, 0, 0, 0, po, so, pe, se);
      if (i == 0) begin
        checks++;
        if (po !== 1'(pe)) begin errors++; $display("FAIL init_prediction: got %0b expected %0b", po, pe); end
        checks++;
        if (so !== 10'(se)) begin errors++; $display("FAIL init_snap: got %0h expected %0h", so, se); end
      end
      checks++;
      if (o_ready !== 1'(ready_m)) begin
        errors++; $display("FAIL init_ready cycle %0d: got %0b expected %0b", i + 1, o_ready, ready_m);
      end
    end
    // Feedback during the sweep must not have trained idx 4.
    apply(1, 0, 32'h0040_0010, 0, 0, 0, 0, 0, po, so, pe, se);
    checks++;
    if (po !== 1'(pe)) begin errors++; $display("FAIL init_no_train: got %0b expected %0b", po, pe); end
  endtask

  task automatic test_training();
    logic po; logic [9:0] so; bit pe; int se;
    bit dirs[7] = '{1, 1, 1, 0, 0, 0, 0};
    for (int k = 0; k < 7; k++) begin
      apply(0, 0, 0, 1, 32'h0040_0010, 0, dirs[k], dirs[k], po, so, pe, se);
      apply(1, 0, 32'h0040_0010, 0, 0, 0, 0, 0, po, so, pe, se);
      checks++;
      if (po !== 1'(pe)) begin errors++; $display("FAIL train_step%0d: got %0b expected %0b", k, po, pe); end
    end
    checks++;
    if (o_mispredicts !== misp_m) begin errors++; $display("FAIL train_misp: got %0d expected %0d", o_mispredicts, misp_m); end
  endtask

  task automatic test_history();
    logic po; logic [9:0] so; bit pe; int se;
    logic [31:0] pcs[3] = '{32'h0040_0010, 32'h0040_0020, 32'h0040_0010};
    for (int k = 0; k < 2; k++) begin
      apply(0, 0, 0, 1, 32'h0040_0010, 0, 1, 1, po, so, pe, se);
      apply(0, 0, 0, 1, 32'h0040_0018, 0, 1, 1, po, so, pe, se);
    end
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, pcs[k], 0, 0, 0, 0, 0, po, so, pe, se);
      checks++;
      if (po !== 1'(pe)) begin errors++; $display("FAIL hist_pred%0d: got %0b expected %0b", k, po, pe); end
      checks++;
      if (so !== 10'(se)) begin errors++; $display("FAIL hist_snap%0d: got %0h expected %0h", k, so, se); end
    end
    checks++;
    if (o_req_ghr_snap !== 10'(ghr_m)) begin errors++; $display("FAIL hist_final: got %0h expected %0h", o_req_ghr_snap, ghr_m); end
    for (int k = 0; k < 5; k++) apply(1, 0, 32'h0040_0010, 0, 0, 0, 0, 0, po, so, pe, se);
    checks++;
    if (o_req_ghr_snap !== 10'(ghr_m)) begin errors++; $display("FAIL hist_stall: got %0h expected %0h", o_req_ghr_snap, ghr_m); end
    checks++;
    if (o_lookups !== lookups_m) begin errors++; $display("FAIL hist_lookups: got %0d expected %0d", o_lookups, lookups_m); end
  endtask

  task automatic test_repair();
    logic po; logic [9:0] so; bit pe; int se;
    apply(1, 1, 32'h0040_0010, 1, 32'h0040_0040, 5, 0, 1, po, so, pe, se);
    checks++;
    if (o_req_ghr_snap !== 10'(ghr_m)) begin errors++; $display("FAIL repair_ghr: got %0h expected %0h", o_req_ghr_snap, ghr_m); end
    checks++;
    if (o_mispredicts !== misp_m) begin errors++; $display("FAIL repair_misp: got %0d expected %0d", o_mispredicts, misp_m); end
    checks++;
    if (o_lookups !== lookups_m) begin errors++; $display("FAIL repair_lookups: got %0d expected %0d", o_lookups, lookups_m); end
  endtask

  task automatic test_collision();
    logic po; logic [9:0] so; bit pe; int se;
    apply(1, 0, 32'h0040_0100, 1, 32'h0040_0100, ghr_m, 1, 1, po, so, pe, se);
    checks++;
    if (po !== 1'(pe)) begin errors++; $display("FAIL collide_same_cycle: got %0b expected %0b", po, pe); end
    apply(1, 0, 32'h0040_0100, 0, 0, 0, 0, 0, po, so, pe, se);
    checks++;
    if (po !== 1'(pe)) begin errors++; $display("FAIL collide_next_cycle: got %0b expected %0b", po, pe); end
  endtask

  task automatic test_random();
    logic po; logic [9:0] so; bit pe; int se;
    logic [31:0] pc, fpc;
    for (int n = 0; n < 400; n++) begin
      pc  = 32'h0040_0000 + 32'($urandom_range(0, 15) * 4);
      fpc = 32'h0040_0000 + 32'($urandom_range(0, 15) * 4);
      apply(1'($urandom), 1'($urandom), pc, ($urandom_range(0, 1) == 1), fpc,
            int'($urandom_range(0, ENTRIES - 1)), 1'($urandom), 1'($urandom), po, so, pe, se);
      checks++;
      if (po !== 1'(pe) || so !== 10'(se)) begin
        errors++; $display("FAIL rand_lookup %0d: got %0b/%0h expected %0b/%0h", n, po, so, pe, se);
      end
      checks++;
      if (o_lookups !== lookups_m || o_mispredicts !== misp_m) begin
        errors++; $display("FAIL rand_counters %0d: got %0d/%0d expected %0d/%0d",
                           n, o_lookups, o_mispredicts, lookups_m, misp_m);
      end
    end
  endtask

  task automatic test_async_reset();
    logic po; logic [9:0] so; bit pe; int se;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %0b expected 0", o_ready); end
    checks++;
    if (o_req_ghr_snap !== 10'h000) begin errors++; $display("FAIL areset_ghr: got %0h expected 0", o_req_ghr_snap); end
    checks++;
    if (o_lookups !== 32'd0 || o_mispredicts !== 32'd0) begin
      errors++; $display("FAIL areset_counters: got %0d/%0d expected 0/0", o_lookups, o_mispredicts);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, po, so, pe, se);
      checks++;
      if (o_ready !== 1'(ready_m)) begin
        errors++; $display("FAIL reinit_ready cycle %0d: got %0b expected %0b", i + 1, o_ready, ready_m);
      end
    end
    apply(1, 0, 32'h0040_0010, 0, 0, 0, 0, 0, po, so, pe, se);
    checks++;
    if (po !== 1'(pe)) begin errors++; $display("FAIL reinit_weak_nt: got %0b expected %0b", po, pe); end
  endtask

  initial begin
    test_reset();
    test_training();
    test_history();
    test_repair();
    test_collision();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
